// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, flag and branch-decode definitions
// Purpose: opcode constants, flag bit positions and the branch decode helpers
//          used by branch_interrupt_controller.
// Ports:   none (package).
`timescale 1ns/1ps
package cpu_pkg;

  localparam int OPC_W = 5;

  // execute-stage flag vector layout {Z,C,N,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [OPC_W-1:0] OPC_JMP  = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_CALL = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_RET  = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_RETI = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_JC   = 5'b11100;
  localparam logic [OPC_W-1:0] OPC_JNC  = 5'b11101;
  localparam logic [OPC_W-1:0] OPC_JZ   = 5'b11110;
  localparam logic [OPC_W-1:0] OPC_JNZ  = 5'b11111;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_JMP,
    BR_CALL,
    BR_RET,
    BR_RETI,
    BR_JCC
  } br_kind_e;

  function automatic br_kind_e decode_op(input logic [OPC_W-1:0] opc);
    case (opc)
      OPC_JMP:                           return BR_JMP;
      OPC_CALL:                          return BR_CALL;
      OPC_RET:                           return BR_RET;
      OPC_RETI:                          return BR_RETI;
      OPC_JC, OPC_JNC, OPC_JZ, OPC_JNZ:  return BR_JCC;
      default:                           return BR_NONE;
    endcase
  endfunction

  function automatic logic jcc_taken(input logic [OPC_W-1:0] opc,
                                     input logic z, input logic c);
    case (opc)
      OPC_JC:  return c;
      OPC_JNC: return !c;
      OPC_JZ:  return z;
      OPC_JNZ: return !z;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - non-wrapping return-address stack with sticky error
// Purpose: LIFO of return addresses. Push when full and pop when empty are
//          discarded and latch err. Reset empties the stack and its contents.
// Ports:   clk, reset (async active-low), push, pop, push_data in;
//          data (top entry, 0 when empty), full, empty, err out.
`timescale 1ns/1ps
module return_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] data,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign full    = (ptr_q == PTR_W'(DEPTH));
  assign empty   = (ptr_q == '0);
  assign wr_idx  = IDX_W'(ptr_q);
  assign top_idx = IDX_W'(ptr_q - 1'b1);
  assign data    = empty ? '0 : mem_q[top_idx];
  assign err     = err_q;

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    err_d = err_q | (push & full) | (pop & empty);
    if (push) begin
      if (!full) begin
        mem_d[wr_idx] = push_data;
        ptr_d         = ptr_q + 1'b1;
      end
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/branch_interrupt_controller.sv
// rtl/branch_interrupt_controller.sv - branch redirect and vectored interrupt entry
// Purpose: decodes branches in the decode slot, resolves conditional jumps
//          against execute flags, manages CALL/RET through a return stack and
//          accepts edge-detected interrupts (lowest line wins, no nesting).
// Ports:   clk, reset (async active-low), ins, current_address, flag_ex,
//          interrupt in; pc_mux_sel, jmp_loc, flush, isr_active, stack_err out.
`timescale 1ns/1ps
module branch_interrupt_controller
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                INS_W       = 20,
  parameter int                NUM_IRQ     = 4,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE    = 8'hF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INS_W-1:0]   ins,
  input  logic [ADDR_W-1:0]  current_address,
  input  logic [3:0]         flag_ex,
  input  logic [NUM_IRQ-1:0] interrupt,
  output logic               pc_mux_sel,
  output logic [ADDR_W-1:0]  jmp_loc,
  output logic               flush,
  output logic               isr_active,
  output logic               stack_err
);

  localparam int IRQ_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [OPC_W-1:0]   opcode;
  logic [ADDR_W-1:0]  target;
  br_kind_e           br_kind;

  logic [NUM_IRQ-1:0] irq_hist_q, pending_q, pending_d, irq_rise;
  logic               pc_mux_sel_q, pc_mux_sel_d;
  logic [ADDR_W-1:0]  jmp_loc_q, jmp_loc_d;
  logic               isr_active_q, isr_active_d;
  logic [IRQ_W-1:0]   irq_idx;
  logic               irq_take;

  logic               stk_push, stk_pop, stk_full, stk_empty;
  logic [ADDR_W-1:0]  stk_push_data, stk_top;

  logic               unused_bits;

  assign opcode   = ins[INS_W-1:INS_W-OPC_W];
  assign target   = ins[ADDR_W-1:0];
  assign br_kind  = decode_op(opcode);
  assign irq_rise = interrupt & ~irq_hist_q;

  // Middle instruction bits and N/V flags take no part in branching.
  assign unused_bits = ^{ins[INS_W-OPC_W-1:ADDR_W], flag_ex[FLAG_N], flag_ex[FLAG_V]};

  // Lowest pending index wins.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) irq_idx = IRQ_W'(i);
    end
  end

  // Acceptance is held off in the flush shadow so the pushed return address
  // is always that of a real, on-path instruction.
  assign irq_take = (|pending_q) && !isr_active_q && !stk_full && !pc_mux_sel_q;

  always_comb begin
    pending_d     = pending_q | irq_rise;
    pc_mux_sel_d  = 1'b0;
    jmp_loc_d     = jmp_loc_q;
    isr_active_d  = isr_active_q;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = current_address + 1'b1;

    if (irq_take) begin
      // The slot instruction is squashed and becomes the resume point.
      stk_push           = 1'b1;
      stk_push_data      = current_address;
      jmp_loc_d          = VEC_BASE + ADDR_W'(irq_idx);
      pc_mux_sel_d       = 1'b1;
      isr_active_d       = 1'b1;
      pending_d[irq_idx] = irq_rise[irq_idx];
    end else if (!pc_mux_sel_q) begin
      unique case (br_kind)
        BR_JMP: begin
          pc_mux_sel_d = 1'b1;
          jmp_loc_d    = target;
        end
        BR_CALL: begin
          stk_push     = 1'b1;
          pc_mux_sel_d = 1'b1;
          jmp_loc_d    = target;
        end
        BR_JCC: begin
          if (jcc_taken(opcode, flag_ex[FLAG_Z], flag_ex[FLAG_C])) begin
            pc_mux_sel_d = 1'b1;
            jmp_loc_d    = target;
          end
        end
        BR_RET, BR_RETI: begin
          stk_pop      = 1'b1;
          pc_mux_sel_d = 1'b1;
          jmp_loc_d    = stk_empty ? '0 : stk_top;
          if (br_kind == BR_RETI) isr_active_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_hist_q   <= '0;
      pending_q    <= '0;
      pc_mux_sel_q <= 1'b0;
      jmp_loc_q    <= '0;
      isr_active_q <= 1'b0;
    end else begin
      irq_hist_q   <= interrupt;
      pending_q    <= pending_d;
      pc_mux_sel_q <= pc_mux_sel_d;
      jmp_loc_q    <= jmp_loc_d;
      isr_active_q <= isr_active_d;
    end
  end

  return_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (stk_push_data),
    .data      (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stack_err)
  );

  assign pc_mux_sel = pc_mux_sel_q;
  assign flush      = pc_mux_sel_q;
  assign jmp_loc    = jmp_loc_q;
  assign isr_active = isr_active_q;

endmodule

// File: tb/tb_branch_interrupt_controller.sv
// tb/tb_branch_interrupt_controller.sv - directed self-checking bench for branch_interrupt_controller
`timescale 1ns/1ps
module tb_branch_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] ins;
  logic [7:0]  current_address;
  logic [3:0]  flag_ex;
  logic [3:0]  interrupt;
  logic        pc_mux_sel;
  logic [7:0]  jmp_loc;
  logic        flush;
  logic        isr_active;
  logic        stack_err;

  int n_pass  = 0;
  int n_total = 0;

  branch_interrupt_controller dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .current_address (current_address),
    .flag_ex         (flag_ex),
    .interrupt       (interrupt),
    .pc_mux_sel      (pc_mux_sel),
    .jmp_loc         (jmp_loc),
    .flush           (flush),
    .isr_active      (isr_active),
    .stack_err       (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Packs {pc_mux_sel, flush, isr_active, stack_err, jmp_loc} into one compare.
  task automatic expect_out(input string tag, input logic pc, input logic [7:0] jl,
                            input logic isr, input logic err);
    check_eq(tag, {20'd0, pc_mux_sel, flush, isr_active, stack_err, jmp_loc},
                  {20'd0, pc, pc, isr, err, jl});
  endtask

  // Drive one decode-slot cycle, advance one rising edge, sample 1 ns later.
  task automatic cyc(input logic [19:0] i, input logic [7:0] a, input logic [3:0] f);
    ins             = i;
    current_address = a;
    flag_ex         = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ins = '0; current_address = '0; flag_ex = '0; interrupt = '0;
    #12;
    expect_out("reset_state", 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    cyc(20'h00000, 8'h00, 4'h0); expect_out("idle",        1'b0, 8'h00, 1'b0, 1'b0);
    cyc(20'hC0008, 8'h04, 4'h0); expect_out("jmp",         1'b1, 8'h08, 1'b0, 1'b0);
    cyc(20'hC0020, 8'h05, 4'h0); expect_out("jmp_shadow",  1'b0, 8'h08, 1'b0, 1'b0);
    cyc(20'h00000, 8'h08, 4'h0); expect_out("jmp_hold",    1'b0, 8'h08, 1'b0, 1'b0);

    // Asynchronous reset asserted mid-cycle while outputs are non-zero.
    cyc(20'hC0008, 8'h04, 4'h0); expect_out("jmp_again",   1'b1, 8'h08, 1'b0, 1'b0);
    ins = '0;
    #3 reset = 1'b0;
    #1 expect_out("reset_async", 1'b0, 8'h00, 1'b0, 1'b0);
    #297 expect_out("reset_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    cyc(20'h00000, 8'h00, 4'h0); expect_out("post_reset",  1'b0, 8'h00, 1'b0, 1'b0);

    // Conditional jumps resolved against flag_ex in the same cycle.
    cyc(20'hF8008, 8'h04, 4'h8); expect_out("jnz_f8",      1'b0, 8'h00, 1'b0, 1'b0);
    cyc(20'hF8008, 8'h04, 4'hA); expect_out("jnz_fa",      1'b0, 8'h00, 1'b0, 1'b0);
    cyc(20'hF8008, 8'h04, 4'h2); expect_out("jnz_f2",      1'b1, 8'h08, 1'b0, 1'b0);
    cyc(20'h00000, 8'h08, 4'h0); expect_out("jnz_after",   1'b0, 8'h08, 1'b0, 1'b0);
    cyc(20'hE0040, 8'h09, 4'h4); expect_out("jc_taken",    1'b1, 8'h40, 1'b0, 1'b0);
    cyc(20'h00000, 8'h40, 4'h0);

    // CALL then RET.
    cyc(20'hC8030, 8'h04, 4'h0); expect_out("call",        1'b1, 8'h30, 1'b0, 1'b0);
    cyc(20'h00000, 8'h30, 4'h0); expect_out("call_shadow", 1'b0, 8'h30, 1'b0, 1'b0);
    cyc(20'h80000, 8'h30, 4'h0); expect_out("ret",         1'b1, 8'h05, 1'b0, 1'b0);
    cyc(20'h00000, 8'h05, 4'h0); expect_out("ret_shadow",  1'b0, 8'h05, 1'b0, 1'b0);

    // Interrupts on lines 1 and 2; JMP in the slot is squashed.
    interrupt = 4'b0110;
    cyc(20'h00000, 8'h0F, 4'h0); expect_out("irq_capture", 1'b0, 8'h05, 1'b0, 1'b0);
    cyc(20'hC0008, 8'h10, 4'h0); expect_out("irq1_accept", 1'b1, 8'hF1, 1'b1, 1'b0);
    cyc(20'h00000, 8'hF1, 4'h0); expect_out("isr1_shadow", 1'b0, 8'hF1, 1'b1, 1'b0);
    cyc(20'h90000, 8'hF1, 4'h0); expect_out("reti1",       1'b1, 8'h10, 1'b0, 1'b0);
    cyc(20'h00000, 8'h10, 4'h0); expect_out("reti1_shadow",1'b0, 8'h10, 1'b0, 1'b0);
    cyc(20'hC0008, 8'h10, 4'h0); expect_out("irq2_accept", 1'b1, 8'hF2, 1'b1, 1'b0);
    interrupt = 4'b0000;
    cyc(20'h00000, 8'hF2, 4'h0);
    cyc(20'h90000, 8'hF2, 4'h0); expect_out("reti2",       1'b1, 8'h10, 1'b0, 1'b0);
    cyc(20'h00000, 8'h10, 4'h0);
    cyc(20'hC0008, 8'h10, 4'h0); expect_out("jmp_resumed", 1'b1, 8'h08, 1'b0, 1'b0);
    cyc(20'h00000, 8'h08, 4'h0);

    // Five CALLs into a four-deep stack, then drain and underflow.
    for (int k = 1; k <= 5; k++) begin
      cyc(20'hC8030, 8'(k), 4'h0);
      expect_out($sformatf("call_%0d", k), 1'b1, 8'h30, 1'b0, (k == 5));
      cyc(20'h00000, 8'h30, 4'h0);
    end
    for (int k = 5; k >= 2; k--) begin
      cyc(20'h80000, 8'h30, 4'h0);
      expect_out($sformatf("ret_pop_%0d", k), 1'b1, 8'(k), 1'b0, 1'b1);
      cyc(20'h00000, 8'(k), 4'h0);
    end
    cyc(20'h80000, 8'h30, 4'h0); expect_out("ret_empty",   1'b1, 8'h00, 1'b0, 1'b1);
    cyc(20'h00000, 8'h00, 4'h0);

    // Reset after a CALL discards the pushed return address.
    cyc(20'hC8030, 8'h04, 4'h0); expect_out("call_pre_rst",1'b1, 8'h30, 1'b0, 1'b1);
    ins = '0;
    #3 reset = 1'b0;
    #1 expect_out("reset_mid_call", 1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    cyc(20'h80000, 8'h30, 4'h0); expect_out("ret_after_rst", 1'b1, 8'h00, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
